// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the sequential Karatsuba multiplier controller.
package karatsuba_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_MUL_H   = 3'd1;
    localparam state_t ST_MUL_L   = 3'd2;
    localparam state_t ST_MUL_M   = 3'd3;
    localparam state_t ST_COMBINE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    localparam int DEF_N        = 32;
    localparam int DEF_APX_BITS = 4;

    function automatic int half_w(input int n);
        return n / 2;
    endfunction

    // S1*S2 needs two bits beyond N; mid needs one more for its sign.
    function automatic int m3_w(input int n);
        return n + 2;
    endfunction

    function automatic int mid_w(input int n);
        return n + 3;
    endfunction

endpackage

// File: rtl/kmul_core.sv
// Combinational unsigned W x W multiplier shared by all three partial products.
module kmul_core #(
    parameter int W = 17
) (
    input  logic [W-1:0]   x_i,
    input  logic [W-1:0]   y_i,
    output logic [2*W-1:0] prod_o
);

    assign prod_o = {{W{1'b0}}, x_i} * {{W{1'b0}}, y_i};

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiplier: one shared (K+1)x(K+1) multiplier, FSM-sequenced.
// Define KARATSUBA_SEQ_APPROX_EN to clear the low APX_BITS of the L and M operands.
module karatsuba_seq_ctrl
    import karatsuba_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int APX_BITS = DEF_APX_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    localparam int K    = half_w(N);
    localparam int M3W  = m3_w(N);
    localparam int MIDW = mid_w(N);

`ifdef KARATSUBA_SEQ_APPROX_EN
    localparam bit APX_EN = 1'b1;
`else
    localparam bit APX_EN = 1'b0;
`endif

    localparam logic [K:0] APX_LOW  = ((K+1)'(1) << APX_BITS) - (K+1)'(1);
    localparam logic [K:0] APX_MASK = APX_EN ? ~APX_LOW : {(K+1){1'b1}};

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, b_q;
    logic [N-1:0]     m1_q, m2_q;
    logic [M3W-1:0]   m3_q;
    logic [2*N-1:0]   p_q, p_d;

    logic [K:0]       s1, s2;
    logic [K:0]       mul_x, mul_y;
    logic [M3W-1:0]   prod;
    logic [MIDW-1:0]  mid;
    logic [2*N-1:0]   mid_ext;

    assign s1 = {1'b0, a_q[N-1:K]} + {1'b0, a_q[K-1:0]};
    assign s2 = {1'b0, b_q[N-1:K]} + {1'b0, b_q[K-1:0]};

    // The high product stays exact; only L and M see the approximation mask.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            ST_MUL_H: begin
                mul_x = {1'b0, a_q[N-1:K]};
                mul_y = {1'b0, b_q[N-1:K]};
            end
            ST_MUL_L: begin
                mul_x = {1'b0, a_q[K-1:0]} & APX_MASK;
                mul_y = {1'b0, b_q[K-1:0]} & APX_MASK;
            end
            ST_MUL_M: begin
                mul_x = s1 & APX_MASK;
                mul_y = s2 & APX_MASK;
            end
            default: ;
        endcase
    end

    kmul_core #(.W(K + 1)) u_mul (
        .x_i    (mul_x),
        .y_i    (mul_y),
        .prod_o (prod)
    );

    // With approximation mid can go negative, so it is sign-extended before the shift.
    assign mid     = {1'b0, m3_q} - {3'b000, m1_q} - {3'b000, m2_q};
    assign mid_ext = {{(2*N-MIDW){mid[MIDW-1]}}, mid};
    assign p_d     = {m1_q, {N{1'b0}}} + (mid_ext << K) + {{N{1'b0}}, m2_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (in_valid) state_d = ST_MUL_H;
            ST_MUL_H:   state_d = ST_MUL_L;
            ST_MUL_L:   state_d = ST_MUL_M;
            ST_MUL_M:   state_d = ST_COMBINE;
            ST_COMBINE: state_d = ST_DONE;
            ST_DONE:    if (out_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == ST_MUL_H)   m1_q <= prod[N-1:0];
            if (state_q == ST_MUL_L)   m2_q <= prod[N-1:0];
            if (state_q == ST_MUL_M)   m3_q <= prod;
            if (state_q == ST_COMBINE) p_q  <= p_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign p         = p_q;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Directed bench for karatsuba_seq_ctrl with a result scoreboard (N = 32, APX_BITS = 4).
module tb_karatsuba_seq_ctrl;

    localparam int N   = 32;
    localparam int APX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          in_ready, out_valid, busy;
    logic [2*N-1:0] p;

    karatsuba_seq_ctrl #(.N(N), .APX_BITS(APX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_fail = 0, n_chk = 0;
    logic [63:0] sb[$];
    int acc_edge, hs_edge, first_ov;
    bit acc_seen, hs_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact product, or Karatsuba with the low bits of L/M operands cleared.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
`ifdef KARATSUBA_SEQ_APPROX_EN
        logic [16:0] m, xl, yl, sx, sy;
        logic [63:0] h, l, md;
        m  = ~17'((1 << APX) - 1);
        xl = {1'b0, x[15:0]} & m;
        yl = {1'b0, y[15:0]} & m;
        sx = (17'(x[31:16]) + 17'(x[15:0])) & m;
        sy = (17'(y[31:16]) + 17'(y[15:0])) & m;
        h  = 64'(x[31:16]) * 64'(y[31:16]);
        l  = 64'(xl) * 64'(yl);
        md = 64'(sx) * 64'(sy) - h - l;
        r  = (h << 32) + (md << 16) + l;
`else
        r = 64'(x) * 64'(y);
`endif
        return r;
    endfunction

    // One clock: observe both handshakes at the falling edge, then let the edge happen.
    task automatic cycle_step();
        @(negedge clk);
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
            else chk("sb_p", p, sb.pop_front());
            hs_edge = cyc + 1;
            hs_seen = 1'b1;
        end
        if (in_valid && in_ready) begin
            sb.push_back(model(a, b));
            acc_edge = cyc + 1;
            acc_seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        in_valid = 1'b1;
        acc_seen = 1'b0;
        first_ov = -1;
        for (int k = 0; k < 40 && !acc_seen; k++) cycle_step();
        if (!acc_seen) chk("accept_timeout", 64'(acc_seen), 64'd1);
    endtask

    task automatic wait_out();
        hs_seen = 1'b0;
        for (int k = 0; k < 40 && !hs_seen; k++) cycle_step();
        if (!hs_seen) chk("result_timeout", 64'(hs_seen), 64'd1);
    endtask

    initial begin
        int acc1;
        logic [63:0] p_hold;
        bit ov_leak;

        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_p", p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-ones operands; result appears 4 edges after the accept edge
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        wait_out();
        chk("latency", 64'(first_ov - acc_edge), 64'd4);
`ifndef KARATSUBA_SEQ_APPROX_EN
        chk("ones_p", p, 64'hFFFF_FFFE_0000_0001);
`endif

        // Stall in DONE for 3 cycles with stray in_valid pulses
        out_ready = 1'b0;
        send(32'h0003_0002, 32'h0005_0004);
        in_valid = 1'b0;
        for (int k = 0; k < 40 && !out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("stall_ov", 64'(out_valid), 64'd1);
        p_hold = p;
        chk("stall_p_model", p_hold, model(32'h0003_0002, 32'h0005_0004));
`ifndef KARATSUBA_SEQ_APPROX_EN
        chk("stall_p", p_hold, 64'h0000_000F_0016_0008);
`endif
        for (int k = 0; k < 3; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1;
            a = 32'hDEAD_0000 + 32'(k);
            b = 32'h0000_BEEF;
            @(negedge clk);
            chk("stall_hold_p", p, p_hold);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_out();
        @(negedge clk);
        chk("retain_p", p, p_hold);
        chk("idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        send(32'h0001_000F, 32'h0001_000F);
        acc1 = acc_edge;
        send(32'h0000_0002, 32'h0000_0003);
        in_valid = 1'b0;
        // Five busy cycles (H, L, M, COMBINE, DONE) separate the accept edges.
        chk("b2b_gap", 64'(acc_edge - acc1), 64'd6);
        chk("b2b_after_hs", 64'(acc_edge - hs_edge), 64'd1);
        wait_out();
`ifndef KARATSUBA_SEQ_APPROX_EN
        chk("b2b_p2", p, 64'd6);
`endif

        // Vectors that expose the approximation
        send(32'h0000_000F, 32'h0000_000F);
        in_valid = 1'b0;
        wait_out();
`ifdef KARATSUBA_SEQ_APPROX_EN
        chk("apx_f", p, 64'd0);
`else
        chk("exact_f", p, 64'hE1);
`endif
        send(32'h0001_000F, 32'h0001_000F);
        in_valid = 1'b0;
        wait_out();
`ifdef KARATSUBA_SEQ_APPROX_EN
        chk("apx_1000f", p, 64'h0000_0001_00FF_0000);
`else
        chk("exact_1000f", p, 64'h0000_0001_001E_00E1);
`endif

        // Reset during MUL_L discards the operation
        send(32'h1234_5678, 32'h9ABC_DEF0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_p", p, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ov_leak = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) ov_leak = 1'b1;
        end
        chk("abort_no_output", 64'(ov_leak), 64'd0);
        chk("abort_in_ready_rel", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(32'd7, 32'd6);
        in_valid = 1'b0;
        wait_out();
        chk("after_abort_p", p, 64'd42);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
